// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake game step sequencer.
package snake_pkg;

  typedef enum logic [1:0] {
    MENU  = 2'd0,
    GAME  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } game_mode;

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT_DIR, MOVE, COLL, GEN, COMMIT, HALT
  } step_state;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    WON  = 2'd1,
    LOST = 2'd2,
    DRAW = 2'd3
  } game_result;

  localparam int DIR_TIMEOUT_DEF   = 750000;
  localparam int STAGE_TIMEOUT_DEF = 4096;
  localparam int TIMER_W           = 20;

  // A simultaneous win and loss counts as a draw.
  function automatic game_result decode_verdict(input logic won, input logic lost,
                                                input logic draw);
    if (draw || (won && lost)) return DRAW;
    else if (won)              return WON;
    else if (lost)             return LOST;
    else                       return NONE;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Saturating up-counter shared by the direction wait and the stage waits.
module step_timer
  import snake_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [TIMER_W-1:0] limit,
  output logic               expired
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)                        cnt <= '0;
    else if (clear)                  cnt <= '0;
    else if (enable && cnt != limit) cnt <= cnt + TIMER_W'(1);
  end

  assign expired = (cnt == limit);

endmodule

// File: rtl/game_step_sequencer.sv
// Runs one game step per tick edge: direction exchange, move, collision,
// point generation, map commit; reports verdict and supervision errors.
//   state    | meaning
//   IDLE     | waiting for a tick edge in GAME mode
//   SEND     | request local direction transmit
//   WAIT_DIR | waiting for peer direction (send_dir high in first cycle)
//   MOVE     | move stage: start cycle, then wait for move_done
//   COLL     | collision stage: start cycle, then wait for coll_done
//   GEN      | point generation: start cycle, then wait for gen_done
//   COMMIT   | map_commit high, step counted
//   HALT     | game over or error; leave by exiting GAME mode
module game_step_sequencer
  import snake_pkg::*;
#(
  parameter int DIR_TIMEOUT   = DIR_TIMEOUT_DEF,
  parameter int STAGE_TIMEOUT = STAGE_TIMEOUT_DEF,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  game_mode         mode,
  input  logic             tick,
  input  logic             rcvdir,
  input  logic             move_done,
  input  logic             coll_done,
  input  logic             won,
  input  logic             lost,
  input  logic             draw,
  input  logic             gen_done,
  output logic             send_dir,
  output logic             move_start,
  output logic             coll_start,
  output logic             gen_start,
  output logic             map_commit,
  output game_result       result,
  output logic             com_err,
  output logic             stall_err,
  output logic             overrun,
  output logic             busy,
  output logic [CNT_W-1:0] step_cnt
);

  step_state          state;
  game_mode           mode_q;
  logic               tick_q;
  logic               tick_rise;
  logic               dir_seen;
  logic               in_wait;
  logic               stage;
  logic               tmr_clear;
  logic               tmr_enable;
  logic               expired;
  logic [TIMER_W-1:0] tmr_limit;

  assign tick_rise  = tick & ~tick_q;
  assign busy       = !((state == IDLE) || (state == HALT));
  assign stage      = (state == MOVE) || (state == COLL) || (state == GEN);
  assign tmr_clear  = (state == SEND) || (stage && !in_wait);
  assign tmr_enable = (state == WAIT_DIR) || (stage && in_wait);
  assign tmr_limit  = (state == WAIT_DIR) ? TIMER_W'(DIR_TIMEOUT - 1)
                                          : TIMER_W'(STAGE_TIMEOUT - 1);

  step_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .limit   (tmr_limit),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mode_q     <= MENU;
      tick_q     <= 1'b0;
      dir_seen   <= 1'b0;
      in_wait    <= 1'b0;
      send_dir   <= 1'b0;
      move_start <= 1'b0;
      coll_start <= 1'b0;
      gen_start  <= 1'b0;
      map_commit <= 1'b0;
      result     <= NONE;
      com_err    <= 1'b0;
      stall_err  <= 1'b0;
      overrun    <= 1'b0;
      step_cnt   <= '0;
    end else begin
      tick_q     <= tick;
      mode_q     <= mode;
      send_dir   <= 1'b0;
      move_start <= 1'b0;
      coll_start <= 1'b0;
      gen_start  <= 1'b0;
      map_commit <= 1'b0;

      if (tick_rise && busy) overrun <= 1'b1;

      if (mode != GAME) begin
        state    <= IDLE;
        in_wait  <= 1'b0;
        dir_seen <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            dir_seen <= tick_rise & rcvdir;
            if (tick_rise) state <= SEND;
          end
          SEND: begin
            send_dir <= 1'b1;
            if (rcvdir) dir_seen <= 1'b1;
            state <= WAIT_DIR;
          end
          WAIT_DIR: begin
            if (rcvdir || dir_seen) begin
              dir_seen   <= 1'b0;
              in_wait    <= 1'b0;
              move_start <= 1'b1;
              state      <= MOVE;
            end else if (expired) begin
              com_err <= 1'b1;
              state   <= HALT;
            end
          end
          MOVE: begin
            if (!in_wait) in_wait <= 1'b1;
            else if (move_done) begin
              in_wait    <= 1'b0;
              coll_start <= 1'b1;
              state      <= COLL;
            end else if (expired) begin
              in_wait   <= 1'b0;
              stall_err <= 1'b1;
              state     <= HALT;
            end
          end
          COLL: begin
            if (!in_wait) in_wait <= 1'b1;
            else if (coll_done) begin
              result    <= decode_verdict(won, lost, draw);
              in_wait   <= 1'b0;
              gen_start <= 1'b1;
              state     <= GEN;
            end else if (expired) begin
              in_wait   <= 1'b0;
              stall_err <= 1'b1;
              state     <= HALT;
            end
          end
          GEN: begin
            if (!in_wait) in_wait <= 1'b1;
            else if (gen_done) begin
              in_wait    <= 1'b0;
              map_commit <= 1'b1;
              step_cnt   <= step_cnt + CNT_W'(1);
              state      <= COMMIT;
            end else if (expired) begin
              in_wait   <= 1'b0;
              stall_err <= 1'b1;
              state     <= HALT;
            end
          end
          COMMIT:  state <= (result != NONE) ? HALT : IDLE;
          HALT:    state <= HALT;
          default: state <= IDLE;
        endcase
      end

      // A fresh game starts with clean status.
      if (mode == GAME && mode_q != GAME) begin
        result    <= NONE;
        com_err   <= 1'b0;
        stall_err <= 1'b0;
        overrun   <= 1'b0;
        step_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_game_step_sequencer.sv
// Directed bench for game_step_sequencer: vector table of full steps plus
// hand sequences for timeouts, overrun, counter wrap and mid-step reset.
module tb_game_step_sequencer;
  import snake_pkg::*;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  game_mode mode;
  logic tick, rcvdir, move_done, coll_done, won, lost, draw, gen_done;
  logic send_dir, move_start, coll_start, gen_start, map_commit;
  game_result result;
  logic com_err, stall_err, overrun, busy;
  logic [CNT_W-1:0] step_cnt;

  game_step_sequencer #(
    .DIR_TIMEOUT   (100),
    .STAGE_TIMEOUT (16),
    .CNT_W         (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .tick       (tick),
    .rcvdir     (rcvdir),
    .move_done  (move_done),
    .coll_done  (coll_done),
    .won        (won),
    .lost       (lost),
    .draw       (draw),
    .gen_done   (gen_done),
    .send_dir   (send_dir),
    .move_start (move_start),
    .coll_start (coll_start),
    .gen_start  (gen_start),
    .map_commit (map_commit),
    .result     (result),
    .com_err    (com_err),
    .stall_err  (stall_err),
    .overrun    (overrun),
    .busy       (busy),
    .step_cnt   (step_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int t_send, t_move, t_coll, t_gen, t_commit, t_com, t_stall;
  int n_send, n_move, n_coll, n_gen, n_commit, n_multi;

  typedef struct {
    int         dir_dly;
    int         done_dly;
    logic       w, l, d;
    game_result exp_res;
    bit         exp_halt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go_game();
    mode = MENU;
    repeat (2) cyc();
    mode = GAME;
    repeat (2) cyc();
  endtask

  // One tick-driven step with an auto-responder: rcvdir dir_dly cycles after
  // send_dir, each done done_dly cycles after its start.
  task automatic run(input int dir_dly, input int done_dly, input logic w,
                     input logic l, input logic d, input bit hold_gen,
                     input int retick, input bit rst_coll, input int ncyc);
    int rc, md, cd, gd;
    rc = -1; md = -1; cd = -1; gd = -1;
    t_send = -1; t_move = -1; t_coll = -1; t_gen = -1; t_commit = -1;
    t_com = -1; t_stall = -1;
    n_send = 0; n_move = 0; n_coll = 0; n_gen = 0; n_commit = 0; n_multi = 0;
    tick = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      cyc();
      rcvdir = 0; move_done = 0; coll_done = 0; gen_done = 0;
      won = 0; lost = 0; draw = 0; rst = 1'b1;
      if (i == 2) tick = 1'b0;
      if (i == retick) tick = 1'b1;
      if (i == retick + 2) tick = 1'b0;
      if (rst_coll && t_coll >= 0 && i == t_coll + 1) begin
        chk("rst_pulses", int'(send_dir) + int'(move_start) + int'(coll_start)
                          + int'(gen_start) + int'(map_commit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_result", int'(result), int'(NONE));
        chk("rst_step_cnt", int'(step_cnt), 0);
        chk("rst_flags", int'({com_err, stall_err, overrun}), 0);
      end
      if (send_dir)   begin n_send++;   if (t_send < 0)   t_send = i;   end
      if (move_start) begin n_move++;   if (t_move < 0)   t_move = i;   end
      if (coll_start) begin n_coll++;   if (t_coll < 0)   t_coll = i;   end
      if (gen_start)  begin n_gen++;    if (t_gen < 0)    t_gen = i;    end
      if (map_commit) begin n_commit++; if (t_commit < 0) t_commit = i; end
      if (com_err && t_com < 0)     t_com = i;
      if (stall_err && t_stall < 0) t_stall = i;
      if (int'(send_dir) + int'(move_start) + int'(coll_start) + int'(gen_start)
          + int'(map_commit) > 1) n_multi++;
      if (rst_coll && coll_start) rst = 1'b0;
      if (rc > 0) rc--;
      if (md > 0) md--;
      if (cd > 0) cd--;
      if (gd > 0) gd--;
      if (send_dir)   rc = dir_dly;
      if (move_start) md = done_dly;
      if (coll_start) cd = done_dly;
      if (gen_start)  gd = done_dly;
      if (rc == 0) begin rcvdir = 1'b1; rc = -1; end
      if (md == 0) begin move_done = 1'b1; md = -1; end
      if (cd == 0) begin coll_done = 1'b1; won = w; lost = l; draw = d; cd = -1; end
      if (gd == 0 && !hold_gen) begin gen_done = 1'b1; gd = -1; end
    end
    cyc();
    rcvdir = 0; move_done = 0; coll_done = 0; gen_done = 0;
    won = 0; lost = 0; draw = 0; rst = 1'b1; tick = 1'b0;
  endtask

  // Raises tick once and reports whether a send_dir follows.
  task automatic probe(output bit seen);
    seen = 0;
    tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (i == 2) tick = 1'b0;
      if (send_dir) seen = 1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int exp_cnt;
    int t;
    vecs[0] = '{3, 2, 1'b0, 1'b0, 1'b0, NONE, 1'b0};
    vecs[1] = '{0, 1, 1'b0, 1'b0, 1'b0, NONE, 1'b0};
    vecs[2] = '{1, 1, 1'b1, 1'b1, 1'b0, DRAW, 1'b1};
    vecs[3] = '{2, 3, 1'b1, 1'b0, 1'b0, WON,  1'b1};
    vecs[4] = '{1, 1, 1'b0, 1'b1, 1'b0, LOST, 1'b1};
    vecs[5] = '{1, 1, 1'b0, 1'b0, 1'b1, DRAW, 1'b1};
    vecs[6] = '{5, 1, 1'b1, 1'b0, 1'b1, DRAW, 1'b1};

    rst = 1'b0; mode = MENU; tick = 0; rcvdir = 0; move_done = 0;
    coll_done = 0; won = 0; lost = 0; draw = 0; gen_done = 0;
    repeat (3) cyc();
    chk("reset_pulses", int'(send_dir) + int'(move_start) + int'(coll_start)
                        + int'(gen_start) + int'(map_commit), 0);
    chk("reset_result", int'(result), int'(NONE));
    chk("reset_flags", int'({com_err, stall_err, overrun}), 0);
    chk("reset_step_cnt", int'(step_cnt), 0);
    chk("reset_busy", int'(busy), 0);
    rst = 1'b1;

    for (int k = 0; k < 7; k++) begin
      go_game();
      run(vecs[k].dir_dly, vecs[k].done_dly, vecs[k].w, vecs[k].l, vecs[k].d,
          1'b0, -1, 1'b0, 40);
      t = t_send + vecs[k].dir_dly + 1;
      chk($sformatf("v%0d_send", k), t_send, 1);
      chk($sformatf("v%0d_move", k), t_move, t);
      t = t + vecs[k].done_dly + 1;
      chk($sformatf("v%0d_coll", k), t_coll, t);
      t = t + vecs[k].done_dly + 1;
      chk($sformatf("v%0d_gen", k), t_gen, t);
      t = t + vecs[k].done_dly + 1;
      chk($sformatf("v%0d_commit", k), t_commit, t);
      chk($sformatf("v%0d_counts", k),
          n_send * 10000 + n_move * 1000 + n_coll * 100 + n_gen * 10 + n_commit, 11111);
      chk($sformatf("v%0d_multi", k), n_multi, 0);
      chk($sformatf("v%0d_result", k), int'(result), int'(vecs[k].exp_res));
      chk($sformatf("v%0d_step_cnt", k), int'(step_cnt), 1);
      chk($sformatf("v%0d_busy", k), int'(busy), 0);
      probe(seen);
      chk($sformatf("v%0d_next_tick", k), int'(seen), int'(!vecs[k].exp_halt));
    end

    // Counter wrap over 16 steps with a 4-bit counter.
    go_game();
    exp_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      run(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 20);
      exp_cnt = (exp_cnt + 1) % 16;
      chk($sformatf("wrap_cnt%0d", k), int'(step_cnt), exp_cnt);
    end

    // Silent peer: one good step, then a direction timeout.
    go_game();
    run(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 20);
    chk("silent_pre_cnt", int'(step_cnt), 1);
    run(1000, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 115);
    chk("silent_com_time", t_com, t_send + 100);
    chk("silent_no_move", n_move, 0);
    chk("silent_busy", int'(busy), 0);
    probe(seen);
    chk("silent_halt_tick", int'(seen), 0);
    mode = MENU;
    repeat (2) cyc();
    chk("silent_menu_com_err", int'(com_err), 1);
    chk("silent_menu_cnt", int'(step_cnt), 1);
    mode = GAME;
    repeat (2) cyc();
    chk("silent_game_com_err", int'(com_err), 0);
    chk("silent_game_cnt", int'(step_cnt), 0);

    // Overrun during MOVE, then a stall in GEN.
    go_game();
    run(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 20);
    run(3, 4, 1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b0, 50);
    chk("ovr_overrun", int'(overrun), 1);
    chk("ovr_move", t_move, t_send + 4);
    chk("ovr_coll", t_coll, t_move + 5);
    chk("ovr_gen", t_gen, t_coll + 5);
    chk("ovr_send_count", n_send, 1);
    chk("stall_time", t_stall, t_gen + 17);
    chk("stall_no_commit", n_commit, 0);
    chk("stall_cnt", int'(step_cnt), 1);
    chk("stall_busy", int'(busy), 0);

    // Reset during COLL; the late coll_done with won=1 must be ignored.
    go_game();
    run(1, 1, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0, 20);
    run(1, 2, 1'b1, 1'b0, 1'b0, 1'b0, -1, 1'b1, 20);
    chk("rstmid_result", int'(result), int'(NONE));
    chk("rstmid_no_gen", n_gen, 0);
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_cnt", int'(step_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
